// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared defaults and constants for the write-back register file.
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 16;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/wb_regfile_mux.sv
// wb_mux: selects load data or FU result as the write-back value.
module wb_mux #(
  parameter int DATA_W = 16
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] fu,
  output logic [DATA_W-1:0] data
);
  assign data = sel ? mem : fu;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back commit into the register file, two bypassed read ports,
// forwarding export and a saturating commit counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              RegWrite_WB,
  input  logic              MemtoReg_WB,
  input  logic [ADDR_W-1:0] RDaddr_WB,
  input  logic [DATA_W-1:0] Mem_Readdata_WB,
  input  logic [DATA_W-1:0] FUResult_WB,
  input  logic [ADDR_W-1:0] RSaddr_ID,
  input  logic [ADDR_W-1:0] RTaddr_ID,
  output logic [DATA_W-1:0] RSdata_ID,
  output logic [DATA_W-1:0] RTdata_ID,
  output logic [DATA_W-1:0] WBdata,
  output logic              WBvalid,
  output logic [ADDR_W-1:0] WBaddr,
  output logic [CNT_W-1:0]  CommitCnt
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  wb_mux #(.DATA_W(DATA_W)) u_mux (
    .sel (MemtoReg_WB),
    .mem (Mem_Readdata_WB),
    .fu  (FUResult_WB),
    .data(WBdata)
  );
  assign WBvalid = RegWrite_WB && !(R0_ZERO && RDaddr_WB == ZERO_ADDR);
  assign WBaddr  = RDaddr_WB;
  // write-first bypass: a reader of the register being committed sees the new value now
  assign RSdata_ID = (R0_ZERO && RSaddr_ID == ZERO_ADDR) ? '0 :
                     (WBvalid && RSaddr_ID == RDaddr_WB) ? WBdata : regs[RSaddr_ID];
  assign RTdata_ID = (R0_ZERO && RTaddr_ID == ZERO_ADDR) ? '0 :
                     (WBvalid && RTaddr_ID == RDaddr_WB) ? WBdata : regs[RTaddr_ID];
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      CommitCnt <= '0;
    end else if (WBvalid) begin
      regs[RDaddr_WB] <= WBdata;
      if (CommitCnt != '1) CommitCnt <= CommitCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of two wb_regfile variants against a behavioural model.
module tb_wb_regfile;
  logic        clk_i = 0;
  logic        rst_n = 0;
  logic        RegWrite_WB = 0, MemtoReg_WB = 0;
  logic [2:0]  RDaddr_WB = 0, RSaddr_ID = 0, RTaddr_ID = 0;
  logic [15:0] Mem_Readdata_WB = 0, FUResult_WB = 0;
  logic [15:0] rs0, rt0, wbd0, rs1, rt1, wbd1;
  logic        wbv0, wbv1;
  logic [2:0]  wba0, wba1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  int          c0, c1;
  int          vectors = 0, miscompares = 0;

  always #5 clk_i = ~clk_i;

  wb_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1'b1), .CNT_W(16)) dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .RDaddr_WB(RDaddr_WB), .Mem_Readdata_WB(Mem_Readdata_WB), .FUResult_WB(FUResult_WB),
    .RSaddr_ID(RSaddr_ID), .RTaddr_ID(RTaddr_ID), .RSdata_ID(rs0), .RTdata_ID(rt0),
    .WBdata(wbd0), .WBvalid(wbv0), .WBaddr(wba0), .CommitCnt(cnt0)
  );
  wb_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1'b0), .CNT_W(4)) dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .RDaddr_WB(RDaddr_WB), .Mem_Readdata_WB(Mem_Readdata_WB), .FUResult_WB(FUResult_WB),
    .RSaddr_ID(RSaddr_ID), .RTaddr_ID(RTaddr_ID), .RSdata_ID(rs1), .RTdata_ID(rt1),
    .WBdata(wbd1), .WBvalid(wbv1), .WBaddr(wba1), .CommitCnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // value a reader should see: the register's post-commit content, with r0 pinned to zero when enabled
  function automatic logic [15:0] exp_rd(input bit r0z, input logic [2:0] a, input bit v,
                                        input logic [2:0] rd, input logic [15:0] d);
    if (r0z && a == 0) return 16'h0;
    if (v && a == rd) return d;
    return r0z ? m0[a] : m1[a];
  endfunction

  task automatic cyc(input logic rw, input logic mtr, input logic [2:0] rd, input logic [15:0] mem,
                     input logic [15:0] fu, input logic [2:0] rs, input logic [2:0] rt);
    logic [15:0] d;
    bit v0, v1;
    @(negedge clk_i);
    RegWrite_WB = rw; MemtoReg_WB = mtr; RDaddr_WB = rd;
    Mem_Readdata_WB = mem; FUResult_WB = fu; RSaddr_ID = rs; RTaddr_ID = rt;
    #1;
    d  = mtr ? mem : fu;
    v0 = rw && rd != 0;
    v1 = rw;
    chk("wbdata0", 32'(wbd0), 32'(d));
    chk("wbdata1", 32'(wbd1), 32'(d));
    chk("wbvalid0", 32'(wbv0), 32'(v0));
    chk("wbvalid1", 32'(wbv1), 32'(v1));
    chk("wbaddr0", 32'(wba0), 32'(rd));
    chk("wbaddr1", 32'(wba1), 32'(rd));
    chk("rs0", 32'(rs0), 32'(exp_rd(1, rs, v0, rd, d)));
    chk("rt0", 32'(rt0), 32'(exp_rd(1, rt, v0, rd, d)));
    chk("rs1", 32'(rs1), 32'(exp_rd(0, rs, v1, rd, d)));
    chk("rt1", 32'(rt1), 32'(exp_rd(0, rt, v1, rd, d)));
    @(posedge clk_i);
    if (v0) begin m0[rd] = d; c0 = (c0 < 65535) ? c0 + 1 : 65535; end
    if (v1) begin m1[rd] = d; c1 = (c1 < 15) ? c1 + 1 : 15; end
    #1;
    chk("cnt0", 32'(cnt0), 32'(c0));
    chk("cnt1", 32'(cnt1), 32'(c1));
  endtask

  // asynchronous reset between edges; a write presented during reset must be lost
  task automatic do_reset();
    @(negedge clk_i);
    RegWrite_WB = 0; RSaddr_ID = 3; RTaddr_ID = 3;
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 8; i++) begin m0[i] = 0; m1[i] = 0; end
    c0 = 0; c1 = 0;
    chk("rst_rs0", 32'(rs0), 0);
    chk("rst_rs1", 32'(rs1), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    RegWrite_WB = 1; RDaddr_WB = 3; MemtoReg_WB = 0; FUResult_WB = 16'hFFFF;
    @(posedge clk_i);
    @(negedge clk_i);
    RegWrite_WB = 0;
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m0[i] = 0; m1[i] = 0; end
    c0 = 0; c1 = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("init_cnt0", 32'(cnt0), 0);
    chk("init_rs1", 32'(rs1), 0);
    @(negedge clk_i) rst_n = 1;
    cyc(0, 0, 0, 0, 0, 3, 7);
    cyc(1, 0, 3, 16'h0, 16'h1234, 3, 1);
    cyc(0, 0, 0, 0, 0, 3, 3);
    do_reset();
    cyc(0, 0, 0, 0, 0, 3, 3);
    cyc(1, 1, 5, 16'hBEEF, 16'h0001, 5, 6);
    cyc(1, 0, 6, 16'hBEEF, 16'h0001, 5, 6);
    cyc(0, 0, 0, 0, 0, 5, 6);
    cyc(1, 0, 2, 16'h0, 16'h0011, 2, 2);
    cyc(1, 0, 2, 16'h0, 16'h00AA, 2, 2);
    cyc(0, 0, 0, 0, 0, 2, 2);
    cyc(1, 0, 0, 16'h0, 16'hFFFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4, 16'h0, 16'h5555, 4, 4);
    cyc(0, 1'bx, 4, 16'h0, 16'h5555, 4, 4);
    cyc(0, 0, 0, 0, 0, 4, 4);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom), 3'($urandom));
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 3'(i % 7 + 1), 16'h0, 16'(i * 3 + 1), 3'(i % 8), 3'((i + 1) % 8));
    chk("sat_cnt1", 32'(cnt1), 32'hF);
    chk("sat_cnt0", 32'(cnt0), 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
